// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer: state encoding, counter
// widths and the level-dependent scroll period helper.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        PAUSE = 3'd2,
        HIT   = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam int LEVEL_MAX    = 9;
    localparam int FLASH_FRAMES = 8;
    localparam int FLASH_BIT    = $clog2(FLASH_FRAMES);

    localparam int FRAME_CNT_W = 5;
    localparam int HIT_CNT_W   = 7;
    localparam int LEVEL_W     = 4;
    localparam int LIVES_W     = 2;
    localparam int SCORE_W     = 14;

    // Frames per scroll step: one fewer per level above 1, never below 1.
    function automatic logic [FRAME_CNT_W-1:0] scroll_period(
        input logic [LEVEL_W-1:0]     lvl,
        input logic [FRAME_CNT_W-1:0] frames_l1
    );
        logic [FRAME_CNT_W-1:0] steps;
        steps = FRAME_CNT_W'(lvl) - FRAME_CNT_W'(1);
        if (steps >= frames_l1) begin
            return FRAME_CNT_W'(1);
        end
        return frames_l1 - steps;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Per-frame tick: synchronises the active-low VGA vsync and emits a registered
// one-clock pulse on each falling edge.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic frame_tick
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;
    logic tick_q;

    // Synchroniser resets to the idle (high) level so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= vsync;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            tick_q  <= dly_q & ~sync2_q;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: FSM over idle/play/pause/hit/over, level-paced scroll strobes,
// and score/level/lives bookkeeping driven by the per-frame tick.
module game_ctrl
    import game_pkg::*;
#(
    parameter int FRAMES_L1  = 8,
    parameter int HIT_FRAMES = 60,
    parameter int LIVES      = 3,
    parameter int LEVEL_PTS  = 100,
    parameter int SCORE_MAX  = 9999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause_sw,
    input  logic               vsync,
    input  logic               collide,
    output state_t             state,
    output logic               run_en,
    output logic               scroll_tick,
    output logic               wall_reset,
    output logic               flash,
    output logic               frame_tick,
    output logic [LEVEL_W-1:0] level,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives
);

    localparam logic [FRAME_CNT_W-1:0] PERIOD_L1 = FRAME_CNT_W'(FRAMES_L1);
    localparam logic [HIT_CNT_W-1:0]   HIT_LIM   = HIT_CNT_W'(HIT_FRAMES);
    localparam logic [LIVES_W-1:0]     LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [SCORE_W-1:0]     SCORE_SAT = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0]     PTS_LAST  = SCORE_W'(LEVEL_PTS - 1);
    localparam logic [LEVEL_W-1:0]     LVL_TOP   = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0]     LVL_ONE   = LEVEL_W'(1);

    state_t                 state_q, state_d;
    logic                   start_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [HIT_CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [SCORE_W-1:0]     pts_q, pts_d;
    logic [LEVEL_W-1:0]     level_q, level_d;
    logic [LIVES_W-1:0]     lives_q, lives_d;
    logic                   run_en_q, run_en_d;
    logic                   scroll_q, scroll_d;
    logic                   wall_q, wall_d;

    logic                   start_edge;
    logic                   frame_tick_w;
    logic [FRAME_CNT_W-1:0] period;
    logic [FRAME_CNT_W-1:0] frame_inc;
    logic [HIT_CNT_W-1:0]   hit_inc;

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .frame_tick (frame_tick_w)
    );

    assign start_edge = start & ~start_q;
    assign period     = scroll_period(level_q, PERIOD_L1);
    assign frame_inc  = frame_cnt_q + FRAME_CNT_W'(1);
    assign hit_inc    = hit_cnt_q + HIT_CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        score_d     = score_q;
        pts_d       = pts_q;
        level_d     = level_q;
        lives_d     = lives_q;
        scroll_d    = 1'b0;
        wall_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d     = PLAY;
                    score_d     = '0;
                    pts_d       = '0;
                    level_d     = LVL_ONE;
                    lives_d     = LIVES_INIT;
                    frame_cnt_d = '0;
                    wall_d      = 1'b1;
                end
            end
            PLAY: begin
                if (collide) begin
                    state_d   = HIT;
                    lives_d   = lives_q - LIVES_W'(1);
                    hit_cnt_d = '0;
                end else if (pause_sw) begin
                    state_d = PAUSE;
                end else if (frame_tick_w) begin
                    if (frame_inc >= period) begin
                        frame_cnt_d = '0;
                        scroll_d    = 1'b1;
                        // pts_q tracks progress toward the next multiple of LEVEL_PTS.
                        if (score_q != SCORE_SAT) begin
                            score_d = score_q + SCORE_W'(1);
                            if (pts_q == PTS_LAST) begin
                                pts_d = '0;
                                if (level_q != LVL_TOP) begin
                                    level_d = level_q + LEVEL_W'(1);
                                end
                            end else begin
                                pts_d = pts_q + SCORE_W'(1);
                            end
                        end
                    end else begin
                        frame_cnt_d = frame_inc;
                    end
                end
            end
            PAUSE: begin
                if (!pause_sw) begin
                    state_d = PLAY;
                end
            end
            HIT: begin
                if (frame_tick_w) begin
                    hit_cnt_d = hit_inc;
                    if (hit_inc >= HIT_LIM) begin
                        if (lives_q == '0) begin
                            state_d = OVER;
                        end else begin
                            state_d     = PLAY;
                            frame_cnt_d = '0;
                            wall_d      = 1'b1;
                        end
                    end
                end
            end
            OVER: begin
                if (start_edge) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        run_en_d = (state_d == PLAY);
    end

    // start_q resets high so a button held through reset needs a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b1;
            frame_cnt_q <= '0;
            hit_cnt_q   <= '0;
            score_q     <= '0;
            pts_q       <= '0;
            level_q     <= LVL_ONE;
            lives_q     <= LIVES_INIT;
            run_en_q    <= 1'b0;
            scroll_q    <= 1'b0;
            wall_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            frame_cnt_q <= frame_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            score_q     <= score_d;
            pts_q       <= pts_d;
            level_q     <= level_d;
            lives_q     <= lives_d;
            run_en_q    <= run_en_d;
            scroll_q    <= scroll_d;
            wall_q      <= wall_d;
        end
    end

    assign state       = state_q;
    assign run_en      = run_en_q;
    assign scroll_tick = scroll_q;
    assign wall_reset  = wall_q;
    assign flash       = (state_q == HIT) && hit_cnt_q[FLASH_BIT];
    assign frame_tick  = frame_tick_w;
    assign level       = level_q;
    assign score       = score_q;
    assign lives       = lives_q;

endmodule
